// File: rtl/seq_pkg.sv
// Shared encodings for the 1011 detector and the hit-window counter that consumes its pulses.
package seq_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_COUNT = 1'b1;

    // Detector states are named by the longest matched prefix of 1011.
    localparam logic [2:0] DET_S0 = 3'd0;
    localparam logic [2:0] DET_S1 = 3'd1;
    localparam logic [2:0] DET_S2 = 3'd2;
    localparam logic [2:0] DET_S3 = 3'd3;
    localparam logic [2:0] DET_S4 = 3'd4;

endpackage

// File: rtl/seq_sat_counter.sv
// CW-bit saturating up-counter with sticky sat flag; exposes the post-increment value before clear.
module seq_sat_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt_nxt,
    output logic          sat_nxt
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sat_q, sat_d;

    always_comb begin
        cnt_nxt = cnt_q;
        sat_nxt = sat_q;
        if (inc) begin
            if (cnt_q == {CW{1'b1}}) begin
                sat_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt_q + 1'b1;
            end
        end
        // Clear wins so the value presented on cnt_nxt can still be captured at window end.
        cnt_d = clr ? '0 : cnt_nxt;
        sat_d = clr ? 1'b0 : sat_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

endmodule

// File: rtl/seq_hit_window.sv
// Counts hit pulses over back-to-back WINDOW-cycle windows; result valid one cycle after the last window cycle.
// A result finding the output still valid and not accepted is dropped and sets sticky overrun.
module seq_hit_window
    import seq_pkg::*;
#(
    parameter int WINDOW = 16,
    parameter int CW     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hit,
    input  logic          enable,
    input  logic          ovr_clr,
    output logic [CW-1:0] cnt_out,
    output logic          cnt_sat,
    output logic          cnt_valid,
    input  logic          cnt_ready,
    output logic          overrun,
    output logic          win_busy
);

    localparam int WCW = $clog2(WINDOW);

    logic [0:0]     state_q, state_d;
    logic [WCW-1:0] win_cnt_q, win_cnt_d;
    logic [CW-1:0]  cnt_out_q, cnt_out_d;
    logic           cnt_sat_q, cnt_sat_d;
    logic           cnt_valid_q, cnt_valid_d;
    logic           overrun_q, overrun_d;
    logic           win_busy_q, win_busy_d;

    logic           running;
    logic           eow;
    logic           load;
    logic           drop;
    logic           acc_clr;
    logic [CW-1:0]  acc_nxt;
    logic           sat_nxt;

    assign running = (state_q == ST_COUNT) && enable;
    assign eow     = running && (win_cnt_q == WCW'(WINDOW - 1));
    assign load    = eow && (!cnt_valid_q || cnt_ready);
    assign drop    = eow && cnt_valid_q && !cnt_ready;
    assign acc_clr = !running || eow;

    seq_sat_counter #(.CW(CW)) u_acc (
        .clk     (clk),
        .rst     (rst),
        .clr     (acc_clr),
        .inc     ((state_q == ST_COUNT) && hit),
        .cnt_nxt (acc_nxt),
        .sat_nxt (sat_nxt)
    );

    always_comb begin
        state_d     = enable ? ST_COUNT : ST_IDLE;
        win_cnt_d   = (running && !eow) ? win_cnt_q + 1'b1 : '0;
        win_busy_d  = (state_d == ST_COUNT);
        cnt_out_d   = cnt_out_q;
        cnt_sat_d   = cnt_sat_q;
        cnt_valid_d = cnt_valid_q;
        if (load) begin
            cnt_out_d   = acc_nxt;
            cnt_sat_d   = sat_nxt;
            cnt_valid_d = 1'b1;
        end else if (cnt_valid_q && cnt_ready) begin
            cnt_valid_d = 1'b0;
        end
        overrun_d = drop ? 1'b1 : (ovr_clr ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            win_cnt_q   <= '0;
            cnt_out_q   <= '0;
            cnt_sat_q   <= 1'b0;
            cnt_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            win_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_cnt_q   <= win_cnt_d;
            cnt_out_q   <= cnt_out_d;
            cnt_sat_q   <= cnt_sat_d;
            cnt_valid_q <= cnt_valid_d;
            overrun_q   <= overrun_d;
            win_busy_q  <= win_busy_d;
        end
    end

    assign cnt_out   = cnt_out_q;
    assign cnt_sat   = cnt_sat_q;
    assign cnt_valid = cnt_valid_q;
    assign overrun   = overrun_q;
    assign win_busy  = win_busy_q;

endmodule

// File: tb/tb_seq_hit_window.sv
// Bench for seq_hit_window: window vector table, scoreboard of expected results, and hand-built corner sequences.
module tb_seq_hit_window;
    import seq_pkg::*;

    localparam int WINDOW = 16;
    localparam int CW     = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          hit;
    logic          enable;
    logic          ovr_clr;
    logic          cnt_ready;
    logic [CW-1:0] cnt_out;
    logic          cnt_sat;
    logic          cnt_valid;
    logic          overrun;
    logic          win_busy;

    seq_hit_window #(.WINDOW(WINDOW), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .hit       (hit),
        .enable    (enable),
        .ovr_clr   (ovr_clr),
        .cnt_out   (cnt_out),
        .cnt_sat   (cnt_sat),
        .cnt_valid (cnt_valid),
        .cnt_ready (cnt_ready),
        .overrun   (overrun),
        .win_busy  (win_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pat;
        int          exp_cnt;
        int          exp_sat;
    } win_vec_t;

    typedef struct {
        int cnt;
        int sat;
    } res_t;

    res_t     sb_q[$];
    win_vec_t vecs[7];
    int       n_tests = 0;
    int       n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full window: hit pattern bit c drives window cycle c.
    task automatic run_window(input logic [15:0] pat, input logic rdy_body, input logic rdy_eow,
                              input int clr_at, input bit push, input int ec, input int es);
        res_t r;
        for (int c = 0; c < WINDOW; c++) begin
            hit       = pat[c];
            cnt_ready = (c == WINDOW - 1) ? rdy_eow : rdy_body;
            ovr_clr   = (c == clr_at);
            if (c == WINDOW - 1 && push) begin
                r.cnt = ec;
                r.sat = es;
                sb_q.push_back(r);
            end
            step();
        end
        hit     = 1'b0;
        ovr_clr = 1'b0;
    endtask

    // Moore 1011 detector reference (overlapping), stream bits MSB first.
    function automatic logic [15:0] det_pattern(input logic [6:0] bits);
        logic [15:0] pat;
        logic [2:0]  st;
        logic        b;
        pat = '0;
        st  = DET_S0;
        for (int i = 0; i < 16; i++) begin
            b      = (i < 7) ? bits[6 - i] : 1'b0;
            pat[i] = (st == DET_S4);
            case (st)
                DET_S0:  st = b ? DET_S1 : DET_S0;
                DET_S1:  st = b ? DET_S1 : DET_S2;
                DET_S2:  st = b ? DET_S3 : DET_S0;
                DET_S3:  st = b ? DET_S4 : DET_S2;
                default: st = b ? DET_S1 : DET_S2;
            endcase
        end
        return pat;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'h8084, 3,  0};
        vecs[1] = '{16'h0000, 0,  0};
        vecs[2] = '{16'hFFFF, 15, 1};
        vecs[3] = '{16'h7FFF, 15, 0};
        vecs[4] = '{16'h5555, 8,  0};
        vecs[5] = '{16'h0001, 1,  0};
        vecs[6] = '{16'h8000, 1,  0};

        rst = 1'b1; hit = 1'b0; enable = 1'b0; ovr_clr = 1'b0; cnt_ready = 1'b0;
        #1;
        chk("rst_cnt_out",   cnt_out,   0);
        chk("rst_cnt_sat",   cnt_sat,   0);
        chk("rst_cnt_valid", cnt_valid, 0);
        chk("rst_overrun",   overrun,   0);
        chk("rst_win_busy",  win_busy,  0);

        fork
            forever begin
                res_t e;
                @(negedge clk);
                if (!rst && cnt_valid && cnt_ready) begin
                    if (sb_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_unexpected: got result %0d with none expected", cnt_out);
                    end else begin
                        e = sb_q.pop_front();
                        chk("sb_cnt", cnt_out, e.cnt);
                        chk("sb_sat", cnt_sat, e.sat);
                    end
                end
            end
        join_none

        step(); step();
        rst = 1'b0;
        step();
        chk("idle_busy", win_busy, 0);

        // Vector table, windows back to back with ready held high.
        cnt_ready = 1'b1;
        enable    = 1'b1;
        step();
        chk("busy_after_enable", win_busy, 1);
        for (int v = 0; v < 7; v++) begin
            run_window(vecs[v].pat, 1'b1, 1'b1, -1, 1'b1, vecs[v].exp_cnt, vecs[v].exp_sat);
            chk("valid_latency", cnt_valid, 1);
        end
        enable = 1'b0;
        step(); step();
        chk("drain_valid", cnt_valid, 0);
        chk("drain_busy",  win_busy,  0);

        // Detector chained in front: 1011011 gives two overlapping matches.
        enable = 1'b1;
        step();
        run_window(det_pattern(7'b1011011), 1'b1, 1'b1, -1, 1'b1, 2, 0);
        enable = 1'b0;
        step(); step();

        // Overrun: hold off ready across two windows, then accept exactly on end-of-window.
        cnt_ready = 1'b0;
        enable    = 1'b1;
        step();
        run_window(16'h0421, 1'b0, 1'b0, -1, 1'b1, 3, 0);
        chk("ovr_first_valid", cnt_valid, 1);
        run_window(16'h1F00, 1'b0, 1'b0, WINDOW - 1, 1'b0, 0, 0);
        chk("ovr_hold_cnt",     cnt_out, 3);
        chk("ovr_drop_beats_clr", overrun, 1);
        run_window(16'h0011, 1'b0, 1'b1, 0, 1'b1, 2, 0);
        chk("ovr_cleared",    overrun, 0);
        chk("ready_eow_load", cnt_out, 2);
        enable = 1'b0;
        step(); step();
        chk("ovr_drain_valid", cnt_valid, 0);

        // Abort at window cycle 9 after four hits, then a fresh window.
        cnt_ready = 1'b1;
        enable    = 1'b1;
        step();
        for (int c = 0; c < 9; c++) begin
            hit = (c % 2 == 0) && (c < 8);
            step();
        end
        enable = 1'b0;
        hit    = 1'b1;
        step();
        hit = 1'b0;
        chk("abort_idle", win_busy, 0);
        step(); step();
        chk("abort_no_valid", cnt_valid, 0);
        enable = 1'b1;
        step();
        run_window(16'h0102, 1'b1, 1'b1, -1, 1'b1, 2, 0);
        enable = 1'b0;
        step(); step();

        // Dropping enable on the end-of-window cycle discards that window.
        enable = 1'b1;
        step();
        for (int c = 0; c < WINDOW - 1; c++) begin
            hit = 1'b1;
            step();
        end
        enable = 1'b0;
        step();
        hit = 1'b0;
        chk("eow_abort_no_valid", cnt_valid, 0);
        step();

        // Asynchronous reset with a pending result and overrun set.
        cnt_ready = 1'b0;
        enable    = 1'b1;
        step();
        run_window(16'h0001, 1'b0, 1'b0, -1, 1'b1, 1, 0);
        run_window(16'h0003, 1'b0, 1'b0, -1, 1'b0, 0, 0);
        chk("pre_rst_overrun", overrun, 1);
        hit = 1'b1;
        step(); step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cnt_out",   cnt_out,   0);
        chk("arst_cnt_valid", cnt_valid, 0);
        chk("arst_overrun",   overrun,   0);
        chk("arst_win_busy",  win_busy,  0);
        sb_q.delete();
        hit = 1'b0;
        rst = 1'b0;
        step();
        chk("post_rst_busy", win_busy, 1);
        enable = 1'b0;
        step(); step();

        chk("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_hit_window.md
Name: seq_hit_window

Overview:
- Downstream consumer of the 1011 sequence detector.
- Takes the detector's single-cycle Moore `out` pulse as `hit` and counts hits over fixed windows of WINDOW clock cycles.
- At the end of each window, presents the count to a downstream reader with a valid/ready handshake.
- Windows run back to back while enabled. Unaccepted results are protected and a sticky overrun flag is raised.

Parameters:
- WINDOW, 16: window length in clk cycles; legal range ≥ 2.
- CW, 4: width of hit count; the count saturates at 2^CW-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- hit  input  1  detector output; every cycle hit=1 counts as one hit
- enable  input  1  1 = run windows continuously; 0 = abort and idle
- ovr_clr  input  1  synchronous clear of overrun
- cnt_out  output  CW  hit count of the last completed window
- cnt_sat  output  1  cnt_out saturated
- cnt_valid  output  1  cnt_out/cnt_sat hold an unconsumed result
- cnt_ready  input  1  downstream accepts the result when cnt_valid && cnt_ready
- overrun  output  1  sticky: a window result was dropped
- win_busy  output  1  1 while in COUNT

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; window counter and hit accumulator = 0.
  - cnt_out=0, cnt_sat=0, cnt_valid=0, overrun=0, win_busy=0.
- Window counter width: $clog2(WINDOW). Accumulator width: CW plus a sat flag.
- FSM states IDLE and COUNT; all outputs are registered.
- IDLE:
  - win_busy=0; counters held at 0.
  - enable=1 → COUNT next cycle; the first COUNT cycle is window cycle 0.
  - hit is ignored in IDLE.
- COUNT, each cycle:
  - win_busy=1.
  - hit=1 → accumulator += 1, saturating at 2^CW-1; sat set on any increment attempted at max.
  - Window counter increments.
- End of window (window counter == WINDOW-1, enable=1):
  - That cycle's hit is included in the result.
  - The result {acc(+hit), sat} is the candidate for the output register.
  - Next cycle, the accumulator and sat clear to 0 (or 1 if hit is captured into the next window — not applicable, windows are disjoint); the window counter wraps to 0; the FSM stays in COUNT.
- Output register load rule at end of window:
  - If cnt_valid=0, or cnt_ready=1 in that same cycle: load cnt_out/cnt_sat, cnt_valid=1 next cycle. No overrun.
  - If cnt_valid=1 and cnt_ready=0: the result is dropped, cnt_out is held unchanged, and overrun=1 next cycle.
- Handshake:
  - cnt_valid && cnt_ready with no simultaneous load → cnt_valid=0 next cycle; cnt_out is held.
  - cnt_out is stable while cnt_valid=1 && cnt_ready=0.
- Latency: a result appears on cnt_out one cycle after the last window cycle.
- enable=0 while in COUNT:
  - Abort at the next edge → IDLE; the partial window is discarded with no result.
  - A pending cnt_valid result remains until accepted.
  - enable=0 on the end-of-window cycle also discards that window.
- overrun:
  - Cleared only by rst or ovr_clr=1.
  - If ovr_clr and a new drop occur in the same cycle, the drop wins (overrun=1).
- hit held high on consecutive cycles counts every cycle; no edge detection, because the detector output is already a single-cycle pulse.

Decomposition:
- Shared package seq_pkg:
  - FSM state encoding constants ST_IDLE and ST_COUNT.
  - Detector state constants, so both blocks use the same encoding source.
- Optional sub-module seq_sat_counter: CW-bit saturating up-counter with clear, increment and sat flag.
- The window counter and handshake register stay inline.

Test Plan:
- Reset: rst pulse mid-run → all outputs 0 within the same cycle (async); enable=1 afterwards → win_busy=1 one cycle later.
- Basic count: WINDOW=16, hit pulsed on window cycles 2, 7, 15, cnt_ready=1 → cnt_out=3, cnt_sat=0, cnt_valid=1 for one cycle, one cycle after cycle 15.
- Chained detector: drive bitstream 1011011 through Seq_detector1 into hit → cnt_out=2.
- Saturation: hit=1 for all 16 cycles → cnt_out=15, cnt_sat=1.
- Overrun:
  - cnt_ready=0 across two full windows (3 hits, then 5 hits) → cnt_out stays 3 and overrun=1.
  - ovr_clr=1 → overrun=0.
  - cnt_ready=1 exactly on an end-of-window cycle → new value loads, no overrun.
- Abort: enable=0 at window cycle 9 with 4 hits → no cnt_valid and state IDLE; re-enable → a fresh window starts from count 0.
